// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and EX-stage ALU state type.
// Used by the decoder and by alu_exec_unit / alu_shifter.
package alu_pkg;

  localparam int unsigned ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_NONE = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [ALUOP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift engine for alu_exec_unit: 1 bit/cycle iterative, or single-cycle barrel
// when ALU_BARREL_SHIFT_EN is defined. done pulses in the cycle the result is valid.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ALUOP_W-1:0] op,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

`ifdef ALU_BARREL_SHIFT_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  // Shift amounts >= WIDTH fall out naturally as 0 / all-sign.
  always_comb begin
    done = start;
    case (op)
      ALU_SLL: result = value << shamt;
      ALU_SRA: result = WIDTH'($signed(value) >>> shamt);
      default: result = value >> shamt;
    endcase
  end

`else

  logic [WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [ALUOP_W-1:0] kind_q, kind_d;
  logic               busy_q, busy_d;
  logic               last_step;
  logic               zero_shift;

  always_comb begin
    case (kind_q)
      ALU_SLL: acc_step = {acc_q[WIDTH-2:0], 1'b0};
      ALU_SRA: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = {1'b0, acc_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    last_step  = busy_q && (cnt_q == SHAMT_W'(1));
    zero_shift = start && (shamt == '0);
    // A zero-length shift completes combinationally so it shares the 1-cycle path.
    done       = zero_shift || last_step;
    result     = zero_shift ? value : acc_step;
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    busy_d = busy_q;
    if (start && !zero_shift) begin
      acc_d  = value;
      cnt_d  = shamt;
      kind_d = op;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kind_q <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      busy_q <= busy_d;
    end
  end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready on both sides; shifts go through alu_shifter.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts (no SHIFT state).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             shift_start;
  logic             sh_done;
  logic [WIDTH-1:0] sh_result;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;

  always_comb begin
    in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept      = in_valid && in_ready;
    shift_start = accept && is_shift_op(alu_op);
  end

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .start  (shift_start),
    .op     (alu_op),
    .value  (op_b),
    .shamt  (shamt),
    .done   (sh_done),
    .result (sh_result)
  );

  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_op)
      ALU_NONE: alu_res = op_a;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SLT: alu_res[0] = $signed(op_a) < $signed(op_b);
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift_op(alu_op)) begin
            if (sh_done) begin
              state_d    = DONE;
              result_d   = sh_result;
              zero_d     = (sh_result == '0);
              overflow_d = 1'b0;
              illegal_d  = 1'b0;
            end
`ifndef ALU_BARREL_SHIFT_EN
            else begin
              state_d = SHIFT;
            end
`endif
          end else begin
            state_d    = DONE;
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ovf;
            illegal_d  = alu_ill;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: begin
        if (sh_done) begin
          state_d    = DONE;
          result_d   = sh_result;
          zero_d     = (sh_result == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    out_valid = (state_q == DONE);
    result    = result_q;
    zero      = zero_q;
    overflow  = overflow_q;
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results plus
// per-scenario inline checks of handshake, latency and reset behaviour.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        i;
  } exp_t;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SRA4_EXTRA = 0;
`else
  localparam int SRA4_EXTRA = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  alu_exec_unit #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t        e;
    logic [32:0] wide;
    e = '0;
    case (op)
      4'd0: e.r = a;
      4'd1: begin wide = {a[31], a} + {b[31], b}; e.r = wide[31:0]; e.v = wide[32] ^ wide[31]; end
      4'd2: begin wide = {a[31], a} - {b[31], b}; e.r = wide[31:0]; e.v = wide[32] ^ wide[31]; end
      4'd3: e.r = a & b;
      4'd4: e.r = a | b;
      4'd5: e.r = ~(a | b);
      4'd6: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: e.r = b << sh;
      4'd8: e.r = b >> sh;
      4'd9: e.r = $signed(b) >>> sh;
      default: e.i = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Scoreboard: every output handshake pops one expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got result=%h with no pending expectation", result);
      end else begin
        e = exp_q.pop_front();
        if ({result, zero, overflow, illegal} !== e) begin
          miscompares++;
          $display("FAIL scoreboard: got result=%h z=%b v=%b i=%b, expected result=%h z=%b v=%b i=%b",
                   result, zero, overflow, illegal, e.r, e.z, e.v, e.i);
        end
      end
    end
  end

  // Drive one request; returns #1 after the accept edge with inputs scrambled.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
    int unsigned guard;
    guard    = 0;
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    shamt    = sh;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(model(op, a, b, sh));
    #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom_range(0, 15));
    op_a     = $urandom;
    op_b     = $urandom;
    shamt    = 5'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h, required 0", result); end
    vectors++; if ({zero, overflow, illegal} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b, required 000", {zero, overflow, illegal}); end
    reset = 1'b0;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_out_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    send(4'd1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: out_valid=%b, required 1", out_valid); end
    vectors++; if ({result, overflow, zero} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL add_ovf: got %h v=%b z=%b, required 80000000 v=1 z=0", result, overflow, zero);
    end
    send(4'd2, 32'h8000_0000, 32'h0000_0001, 5'd0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL sub_ovf: got %b, required 1", overflow); end
    send(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    vectors++; if ({overflow, zero} !== 2'b01) begin miscompares++; $display("FAIL add_wrap: got v=%b z=%b, required v=0 z=1", overflow, zero); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    out_ready = 1'b1;
    send(4'd2, 32'd5, 32'd5, 5'd0);
    vectors++; if ({out_valid, in_ready, zero} !== 3'b111) begin
      miscompares++; $display("FAIL b2b_first: got valid=%b ready=%b zero=%b, required 111", out_valid, in_ready, zero);
    end
    c0 = cyc;
    send(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    vectors++; if (cyc - c0 !== 1) begin miscompares++; $display("FAIL b2b_bubble: accept took %0d cycles, required 1", cyc - c0); end
    vectors++; if ({out_valid, result} !== {1'b1, 32'h00F0_00F0}) begin
      miscompares++; $display("FAIL b2b_second: got valid=%b result=%h, required 1 00f000f0", out_valid, result);
    end
    send(4'd5, 32'h0000_FFFF, 32'hFF00_0000, 5'd0);
    send(4'd0, 32'hDEAD_BEEF, 32'h1, 5'd0);
    tick();
  endtask

  task automatic test_shift_latency();
    int n;
    out_ready = 1'b1;
    send(4'd9, 32'h0, 32'h8000_0000, 5'd4);
`ifndef ALU_BARREL_SHIFT_EN
    vectors++; if ({in_ready, out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL shift_busy: got ready=%b valid=%b, required 00", in_ready, out_valid);
    end
`endif
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    vectors++; if (n !== SRA4_EXTRA) begin miscompares++; $display("FAIL sra_latency: got %0d extra cycles, required %0d", n, SRA4_EXTRA); end
    vectors++; if (result !== 32'hF800_0000) begin miscompares++; $display("FAIL sra_result: got %h, required f8000000", result); end
    send(4'd7, 32'h0, 32'h0000_0003, 5'd3);
    send(4'd8, 32'h0, 32'hF000_0000, 5'd0);
    send(4'd8, 32'h0, 32'h8000_0001, 5'd31);
    send(4'd9, 32'h0, 32'h8000_0000, 5'd31);
    send(4'd7, 32'h0, 32'h8000_0001, 5'd1);
    repeat (40) tick();
  endtask

  task automatic test_slt_illegal();
    out_ready = 1'b1;
    send(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    vectors++; if (result !== 32'd1) begin miscompares++; $display("FAIL slt: got %h, required 1", result); end
    send(4'd6, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0);
    send(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    vectors++; if ({out_valid, illegal, zero, result} !== {3'b111, 32'd0}) begin
      miscompares++; $display("FAIL illegal: got valid=%b ill=%b z=%b result=%h, required 1 1 1 0", out_valid, illegal, zero, result);
    end
    send(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'd4, 32'h1, 32'h2, 5'd0);
    repeat (3) begin
      vectors++; if ({out_valid, in_ready, result} !== {2'b10, 32'd3}) begin
        miscompares++; $display("FAIL hold: got valid=%b ready=%b result=%h, required 1 0 3", out_valid, in_ready, result);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    out_ready = 1'b1;
    send(4'd7, 32'h0, 32'h1234_5678, 5'd20);
    repeat (6) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_shift_valid: got %b, required 0", out_valid); end
    reset = 1'b1;
    exp_q.delete();
    tick();
    vectors++; if ({out_valid, in_ready, result} !== {2'b01, 32'd0}) begin
      miscompares++; $display("FAIL reset_flush: got valid=%b ready=%b result=%h, required 0 1 0", out_valid, in_ready, result);
    end
    reset = 1'b0;
    tick();
    send(4'd7, 32'h0, 32'h1, 5'd1);
`ifdef ALU_BARREL_SHIFT_EN
    vectors++; if (result !== 32'd2) begin miscompares++; $display("FAIL sll_after_reset: got %h, required 2", result); end
`else
    tick();
    vectors++; if (result !== 32'd2) begin miscompares++; $display("FAIL sll_after_reset: got %h, required 2", result); end
`endif
    tick();
  endtask

  task automatic test_random_mix();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, $urandom,
           (i % 7 == 0) ? 5'd31 : 5'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    vectors++; if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_shift_latency();
    test_slt_illegal();
    test_backpressure();
    test_reset_mid_shift();
    test_random_mix();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
